// File: rtl/data_memory.sv
// Word-addressed 32-bit data memory: single clocked write port, combinational
// read port, with out-of-range and reset masking on both sides.
module data_memory #(
  parameter int DEPTH = 262144,
  parameter int AW    = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd
);

  // Contents start at zero and are never cleared by rst, so the array carries
  // a declaration initializer instead of a reset branch.
  logic [31:0] mem_q [DEPTH] = '{default: '0};

  logic          in_range;
  logic [AW-1:0] idx;
  logic          wr_en;

  // Any nonzero bit above the index field is out of range; no aliasing.
  assign in_range = (addr[31:AW] == '0);
  assign idx      = addr[AW-1:0];
  assign wr_en    = we && in_range && !rst;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[idx] <= wd;
  end

  always_comb begin
    rd = '0;
    if (!rst && in_range) rd = mem_q[idx];
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: writes, readback, out-of-range, reset masking.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;

  int tests = 0;
  int fails = 0;

  data_memory #(.DEPTH(262144), .AW(18)) dut (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .addr (addr),
    .wd   (wd),
    .rd   (rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; addr = 32'd77; wd = 32'h0;
    #2;
    chk("reset_rd", rd, 32'h0);
    edge1();
    rst = 1'b0;
    #1;
    chk("powerup_77", rd, 32'h0);

    // back-to-back writes, each visible right after its own edge
    we = 1'b1; addr = 32'd0; wd = 32'h0000AFAF;
    #1 chk("pre_wr0", rd, 32'h0);
    edge1();
    chk("wr0", rd, 32'h0000AFAF);
    addr = 32'd10000; wd = 32'h0000FFFF;
    edge1();
    chk("wr10000", rd, 32'h0000FFFF);
    addr = 32'd152100; wd = 32'hABCDEFAA;
    edge1();
    chk("wr152100", rd, 32'hABCDEFAA);

    we = 1'b0; addr = 32'd0; wd = 32'd1;
    #1 chk("rd0", rd, 32'h0000AFAF);
    addr = 32'd10000;
    #1 chk("rd10000", rd, 32'h0000FFFF);
    addr = 32'd152100;
    #1 chk("rd152100", rd, 32'hABCDEFAA);

    // we=0 across an edge leaves contents alone
    addr = 32'd0;
    edge1();
    chk("we0_edge", rd, 32'h0000AFAF);

    // out of range: ignored, reads zero, no alias into index 0
    we = 1'b1; addr = 32'h0004_0000; wd = 32'h12345678;
    #1 chk("oor_pre", rd, 32'h0);
    edge1();
    chk("oor_rd", rd, 32'h0);
    addr = 32'h8000_0005;
    edge1();
    chk("oor_hi_rd", rd, 32'h0);
    we = 1'b0; addr = 32'd0;
    #1 chk("oor_noalias0", rd, 32'h0000AFAF);
    addr = 32'd5;
    #1 chk("oor_noalias5", rd, 32'h0);

    // reset mid-cycle masks rd at once and blocks writes
    addr = 32'd0;
    #1 rst = 1'b1;
    #1 chk("rst_async_rd", rd, 32'h0);
    we = 1'b1; wd = 32'hDEADBEEF;
    edge1();
    chk("rst_wr_masked", rd, 32'h0);
    we = 1'b0;
    #1 rst = 1'b0;
    #1 chk("rst_keeps_mem", rd, 32'h0000AFAF);

    // same-cycle write/read: old before edge, new after; first write after reset
    addr = 32'd5; we = 1'b1; wd = 32'h55AA55AA;
    #1 chk("a5_pre", rd, 32'h0);
    edge1();
    chk("a5_post", rd, 32'h55AA55AA);
    we = 1'b0; addr = 32'd0;
    #1 chk("a0_indep", rd, 32'h0000AFAF);
    addr = 32'd10000;
    #1 chk("a10000_indep", rd, 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 The block SHALL have parameter DEPTH, default 262144, meaning the number of 32-bit words stored; it SHALL be a power of two and at least 152101.
REQ-002 The block SHALL have parameter AW, default 18, meaning the number of low address bits used to index the array; DEPTH SHALL equal 2**AW.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes SHALL occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port we, input, 1 bit: write enable, sampled on the rising edge of clk.
REQ-006 The block SHALL have port addr, input, 32 bits: word address, where one address step equals one 32-bit word; it is not a byte address.
REQ-007 The block SHALL have port wd, input, 32 bits: write data.
REQ-008 The block SHALL have port rd, output, 32 bits: read data.

Function
REQ-009 The array SHALL hold DEPTH words of 32 bits, and every word SHALL be 0 at power-up.
REQ-010 Write: when rst=0, we=1 and addr<DEPTH at the clk rising edge, mem[addr[AW-1:0]] SHALL take the full 32-bit wd; there are no byte enables and no partial writes.
REQ-011 Write latency SHALL be one edge: the new value is visible on rd immediately after the same edge that commits it.
REQ-012 Read: rd SHALL be combinational, rd = mem[addr[AW-1:0]], with no clock latency, and SHALL be valid regardless of we.
REQ-013 Out-of-range access (addr >= DEPTH, i.e. any of addr[31:AW] nonzero) SHALL be defined as follows:
- a write SHALL be ignored, with no aliasing into the array;
- a read SHALL return 32'h0000_0000.
REQ-014 When we=1 with an unchanged addr, rd SHALL show the old word before the edge and wd after the edge; there is no bypass of wd to rd before the edge.
REQ-015 When we=0, contents SHALL be unchanged by any clock edge.
REQ-016 Back-to-back writes to different addresses on consecutive edges SHALL all commit, one per edge, with no stall.
REQ-017 Addresses 0, 10000 and 152100 SHALL be ordinary in-range locations, independent of each other.

Reset
REQ-018 While rst=1, rd SHALL be forced to 32'h0 asynchronously, without waiting for a clock edge.
REQ-019 While rst=1, writes SHALL be suppressed, including on an edge coincident with rst assertion.
REQ-020 Reset SHALL NOT clear array contents; words written before reset SHALL be readable after rst returns to 0.
REQ-021 After rst deasserts, rd SHALL return combinationally to mem[addr], and the first rising edge with we=1 SHALL write normally.
REQ-022 If rst is asserted in the middle of a write sequence, the suppressed write SHALL leave the previous contents of that address intact.

Verification
REQ-023 Scenario (basic writes and readback): rst=0, we=1.
- Write addr=0, wd=32'h0000AFAF, then addr=10000, wd=32'h0000FFFF, then addr=152100, wd=32'hABCDEFAA, one per edge.
- Then we=0, addr=0, wd=1.
- Required: rd=32'h0000AFAF.
- Required: rereading addr 10000 gives 32'h0000FFFF and addr 152100 gives 32'hABCDEFAA.
REQ-024 Scenario (read with we=0): we=0, wd=1, addr=0, clock edge.
- Required: the word at 0 is unchanged and rd=32'h0000AFAF.
REQ-025 Scenario (out of range): write addr=32'h0004_0000, wd=32'h12345678.
- Required: rd=0 at that address.
- Required: mem[0] is still 32'h0000AFAF, showing no aliasing.
REQ-026 Scenario (reset):
- Assert rst mid-cycle. Required: rd=0 immediately.
- Drive we=1, addr=0, wd=32'hDEADBEEF across an edge while rst=1, then deassert rst.
- Required: rd at addr 0 = 32'h0000AFAF.
REQ-027 Scenario (same-cycle write/read): addr=5 holds 0; we=1, wd=32'h55AA55AA.
- Required: rd=0 before the edge and 32'h55AA55AA after it.
REQ-028 Scenario (power-up): with no prior writes, read addr=77. Required: rd=0.
